// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write request, read ports, PC alias and status.
// Handshake: writeEnable is a one-cycle request with no backpressure; it only takes effect once ready is high.
interface param_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              writeEnable;
    logic [ADDR_W-1:0] writeDestination;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] pcValue;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              writeToPC;
    logic [DATA_W-1:0] pcWriteData;
    logic              ready;

    modport master (
        output writeEnable, writeDestination, writeData, readReg1, readReg2, pcValue,
        input  readData1, readData2, writeToPC, pcWriteData, ready
    );

    modport slave (
        input  writeEnable, writeDestination, writeData, readReg1, readReg2, pcValue,
        output readData1, readData2, writeToPC, pcWriteData, ready
    );
endinterface

// File: rtl/param_register_file.sv
// Register file with a PC-aliased index, same-cycle write bypass and a post-reset clear sweep.
// Reads return 0 until every register has been zeroed; o_dbg_state is 0 in CLEAR, 1 in RUN.
module param_register_file #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_IDX    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    param_register_file_if.slave bus,
    output logic                 o_dbg_state
);
    localparam int                NREG     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
    localparam logic [DATA_W-1:0] OFFSET   = DATA_W'(PC_OFFSET);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clear_idx;
    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_write_to_pc;
    logic [DATA_W-1:0] r_pc_write_data;

    logic              w_run;
    logic              w_pc_write;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_data;

    // The clear sweep owns the array write port while in CLEAR, so user writes are dropped.
    always_comb begin
        w_state_next = r_state;
        w_arr_we     = 1'b0;
        w_arr_addr   = r_clear_idx;
        w_arr_data   = '0;
        w_pc_write   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_arr_we = 1'b1;
                if (r_clear_idx == LAST_IDX) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.writeEnable) begin
                    if (bus.writeDestination == PC_ADDR) begin
                        w_pc_write = 1'b1;
                    end else begin
                        w_arr_we   = 1'b1;
                        w_arr_addr = bus.writeDestination;
                        w_arr_data = bus.writeData;
                    end
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_CLEAR;
            r_clear_idx     <= '0;
            r_write_to_pc   <= 1'b0;
            r_pc_write_data <= '0;
        end else begin
            r_state       <= w_state_next;
            r_write_to_pc <= w_pc_write;
            if (r_state == ST_CLEAR) begin
                r_clear_idx <= r_clear_idx + 1'b1;
            end
            if (w_pc_write) begin
                r_pc_write_data <= bus.writeData;
            end
        end
    end

    // Array has no reset; its contents are hidden behind the CLEAR read gating until swept.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_regs[w_arr_addr] <= w_arr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] reg_val,
        input logic              we,
        input logic [ADDR_W-1:0] dest,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] pc
    );
        if (idx == PC_ADDR) begin
            return pc + OFFSET;
        end else if (we && (dest == idx)) begin
            return wdata;
        end
        return reg_val;
    endfunction

    assign w_run = (r_state == ST_RUN);

    assign bus.readData1 = w_run ? read_port(bus.readReg1, r_regs[bus.readReg1], bus.writeEnable,
                                             bus.writeDestination, bus.writeData, bus.pcValue) : '0;
    assign bus.readData2 = w_run ? read_port(bus.readReg2, r_regs[bus.readReg2], bus.writeEnable,
                                             bus.writeDestination, bus.writeData, bus.pcValue) : '0;
    assign bus.writeToPC   = r_write_to_pc;
    assign bus.pcWriteData = r_pc_write_data;
    assign bus.ready       = w_run;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: directed scenarios plus a randomized model-based phase.
module tb_param_register_file;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int NREG      = 16;
    localparam int PC_IDX    = 15;
    localparam int PC_OFFSET = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_v;
    logic [DATA_W-1:0] exp_pc_data;
    logic [DATA_W-1:0] model [NREG];

    param_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    param_register_file #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .PC_OFFSET(PC_OFFSET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input logic we, input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                         input logic [DATA_W-1:0] pc);
        bus.writeEnable      = we;
        bus.writeDestination = dest;
        bus.writeData        = data;
        bus.readReg1         = r1;
        bus.readReg2         = r2;
        bus.pcValue          = pc;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREG; i++) model[i] = '0;
        exp_pc_data = '0;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] idx, input logic we,
                                                     input logic [ADDR_W-1:0] dest,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [DATA_W-1:0] pc);
        if (idx == ADDR_W'(PC_IDX)) return pc + DATA_W'(PC_OFFSET);
        if (we && dest == idx) return data;
        return model[idx];
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 32'h100);
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL reset_wtpc: got %b expected 0", bus.writeToPC); end
        checks++; if (bus.pcWriteData !== '0) begin errors++; $display("FAIL reset_pcdata: got %h expected 0", bus.pcWriteData); end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < NREG; e++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'h100);
            #1;
            exp_q.push_back('0);
            exp_q.push_back('0);
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL sweep_ready edge %0d: got %b expected 0", e, bus.ready); end
            checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL sweep_wtpc edge %0d: got %b expected 0", e, bus.writeToPC); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL sweep_rd1 edge %0d: got %h expected %h", e, bus.readData1, exp_v); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL sweep_rd2 edge %0d: got %h expected %h", e, bus.readData2, exp_v); end
            @(negedge clk);
        end
        drive(1'b0, '0, '0, '0, '0, 32'h100);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL sweep_done_ready: got %b expected 1", bus.ready); end
        checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL sweep_done_state: got %b expected 1", dbg_state); end
        clear_model();
        for (int i = 0; i < NREG - 1; i++) begin
            drive(1'b0, '0, '0, 4'(i), 4'(NREG - 2 - i), 32'h100);
            #1;
            exp_q.push_back('0);
            exp_q.push_back('0);
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL cleared_rd1 r%0d: got %h expected %h", i, bus.readData1, exp_v); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL cleared_rd2 r%0d: got %h expected %h", NREG - 2 - i, bus.readData2, exp_v); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(1'b1, 4'd8, 32'hAAAAAAAA, '0, '0, 32'h100);
        @(negedge clk);
        model[8] = 32'hAAAAAAAA;
        drive(1'b1, 4'd0, 32'hCCCCCCCC, 4'd8, 4'd0, 32'h100);
        #1;
        exp_q.push_back(32'hAAAAAAAA);
        exp_q.push_back(32'hCCCCCCCC);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL wr_read_r8: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL bypass_r0: got %h expected %h", bus.readData2, exp_v); end
        @(negedge clk);
        model[0] = 32'hCCCCCCCC;
        drive(1'b0, '0, '0, 4'd0, 4'd8, 32'h100);
        #1;
        exp_q.push_back(32'hCCCCCCCC);
        exp_q.push_back(32'hAAAAAAAA);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL stored_r0: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL stored_r8: got %h expected %h", bus.readData2, exp_v); end
    endtask

    task automatic test_pc_write();
        @(negedge clk);
        drive(1'b1, 4'd15, 32'hCCCCCCCC, 4'd15, 4'd15, 32'h100);
        #1;
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h108);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL pc_read_rd1: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL pc_read_rd2: got %h expected %h", bus.readData2, exp_v); end
        @(posedge clk); #1;
        exp_pc_data = 32'hCCCCCCCC;
        checks++; if (bus.writeToPC !== 1'b1) begin errors++; $display("FAIL pc_pulse: got %b expected 1", bus.writeToPC); end
        checks++; if (bus.pcWriteData !== exp_pc_data) begin errors++; $display("FAIL pc_data: got %h expected %h", bus.pcWriteData, exp_pc_data); end
        @(negedge clk);
        drive(1'b0, '0, '0, 4'd15, 4'd3, 32'h100);
        @(posedge clk); #1;
        checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL pc_pulse_end: got %b expected 0", bus.writeToPC); end
        checks++; if (bus.pcWriteData !== exp_pc_data) begin errors++; $display("FAIL pc_data_hold: got %h expected %h", bus.pcWriteData, exp_pc_data); end
        @(negedge clk);
        drive(1'b1, 4'd2, 32'h11111111, 4'd2, 4'd2, 32'h100);
        @(posedge clk); #1;
        model[2] = 32'h11111111;
        checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL normal_wr_wtpc: got %b expected 0", bus.writeToPC); end
        checks++; if (bus.pcWriteData !== exp_pc_data) begin errors++; $display("FAIL normal_wr_pcdata: got %h expected %h", bus.pcWriteData, exp_pc_data); end
    endtask

    task automatic test_pc_wrap();
        @(negedge clk);
        drive(1'b0, '0, '0, 4'd2, 4'd15, 32'hFFFFFFFC);
        #1;
        exp_q.push_back(model[2]);
        exp_q.push_back(32'h00000004);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL wrap_rd1: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL wrap_rd2: got %h expected %h", bus.readData2, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 32'hA5A5A5A5;
        vals[1] = 32'h5A5A5A5A;
        vals[2] = 32'h0F0F0F0F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 4'd5, vals[k], 4'd5, 4'd5, 32'h200);
            #1;
            exp_q.push_back(vals[k]);
            exp_q.push_back(vals[k]);
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL b2b_rd1 #%0d: got %h expected %h", k, bus.readData1, exp_v); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL b2b_rd2 #%0d: got %h expected %h", k, bus.readData2, exp_v); end
        end
        @(negedge clk);
        model[5] = vals[2];
        drive(1'b0, '0, '0, 4'd5, 4'd5, 32'h200);
        #1;
        exp_q.push_back(vals[2]);
        exp_q.push_back(vals[2]);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL b2b_last_rd1: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL b2b_last_rd2: got %h expected %h", bus.readData2, exp_v); end
    endtask

    task automatic test_random(input int cycles);
        logic              we;
        logic [ADDR_W-1:0] dest, r1, r2;
        logic [DATA_W-1:0] data, pc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            we   = 1'($urandom_range(0, 1));
            dest = 4'($urandom_range(0, 15));
            data = $urandom;
            r1   = ($urandom_range(0, 3) == 0) ? dest : 4'($urandom_range(0, 15));
            r2   = ($urandom_range(0, 3) == 0) ? r1 : 4'($urandom_range(0, 15));
            pc   = $urandom;
            drive(we, dest, data, r1, r2, pc);
            #1;
            exp_q.push_back(model_read(r1, we, dest, data, pc));
            exp_q.push_back(model_read(r2, we, dest, data, pc));
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL rand_rd1 cyc %0d r%0d: got %h expected %h", c, r1, bus.readData1, exp_v); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL rand_rd2 cyc %0d r%0d: got %h expected %h", c, r2, bus.readData2, exp_v); end
            @(posedge clk); #1;
            if (we && dest == ADDR_W'(PC_IDX)) exp_pc_data = data;
            else if (we) model[dest] = data;
            checks++; if (bus.writeToPC !== (we && dest == ADDR_W'(PC_IDX))) begin errors++; $display("FAIL rand_wtpc cyc %0d: got %b expected %b", c, bus.writeToPC, (we && dest == ADDR_W'(PC_IDX))); end
            checks++; if (bus.pcWriteData !== exp_pc_data) begin errors++; $display("FAIL rand_pcdata cyc %0d: got %h expected %h", c, bus.pcWriteData, exp_pc_data); end
        end
    endtask

    task automatic test_clear_write();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 32'h100);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            drive(1'b1, 4'd3, 32'h12345678, 4'd3, 4'd15, 32'h100);
            @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midclear_ready: got %b expected 0", bus.ready); end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < NREG; e++) begin
            drive(1'b1, (e % 2 == 1) ? 4'd3 : 4'd15, 32'h12345678, 4'd3, 4'd15, 32'h100);
            #1;
            exp_q.push_back('0);
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL restart_ready edge %0d: got %b expected 0", e, bus.ready); end
            checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL clear_wtpc edge %0d: got %b expected 0", e, bus.writeToPC); end
            exp_v = exp_q.pop_front();
            checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL clear_rd2 edge %0d: got %h expected %h", e, bus.readData2, exp_v); end
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 4'd3, 4'd3, 32'h100);
        #1;
        clear_model();
        exp_q.push_back('0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL restart_done_ready: got %b expected 1", bus.ready); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL clear_ignored_r3: got %h expected %h", bus.readData1, exp_v); end
        checks++; if (bus.pcWriteData !== exp_pc_data) begin errors++; $display("FAIL clear_pcdata: got %h expected %h", bus.pcWriteData, exp_pc_data); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        drive(1'b1, 4'd8, 32'h55, '0, '0, 32'h100);
        @(negedge clk);
        drive(1'b1, 4'd15, 32'hDEADBEEF, 4'd8, 4'd8, 32'h100);
        #1;
        exp_q.push_back(32'h55);
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL run_r8: got %h expected %h", bus.readData1, exp_v); end
        @(posedge clk); #1;
        checks++; if (bus.writeToPC !== 1'b1) begin errors++; $display("FAIL prereset_wtpc: got %b expected 1", bus.writeToPC); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL prereset_ready: got %b expected 1", bus.ready); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.writeToPC !== 1'b0) begin errors++; $display("FAIL async_wtpc: got %b expected 0", bus.writeToPC); end
        checks++; if (bus.pcWriteData !== '0) begin errors++; $display("FAIL async_pcdata: got %h expected 0", bus.pcWriteData); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, '0, '0, 4'd8, 4'd8, 32'h100);
        repeat (NREG - 1) @(negedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL resweep_early_ready: got %b expected 0", bus.ready); end
        @(negedge clk);
        #1;
        clear_model();
        exp_q.push_back('0);
        exp_q.push_back('0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL resweep_ready: got %b expected 1", bus.ready); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData1 !== exp_v) begin errors++; $display("FAIL resweep_r8_rd1: got %h expected %h", bus.readData1, exp_v); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.readData2 !== exp_v) begin errors++; $display("FAIL resweep_r8_rd2: got %h expected %h", bus.readData2, exp_v); end
    endtask

    // test sequence and report
    initial begin
        drive(1'b0, '0, '0, '0, '0, '0);
        clear_model();
        test_reset();
        test_write_read();
        test_pc_write();
        test_pc_wrap();
        test_back_to_back();
        test_random(40);
        test_clear_write();
        test_random(20);
        test_reset_mid_run();
        test_random(20);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
